// File: rtl/cordic_pkg.sv
// ----------------------------------------------------------------------------
// cordic_pkg
//   Definitions shared by the CORDIC cosine unit and its fixed-to-float output
//   stage. It holds the fixed-point format of the CORDIC result, the
//   IEEE-754 single-precision field widths, the state type of the
//   normaliser, and a helper that packs float fields into one word.
// ----------------------------------------------------------------------------
package cordic_pkg;

   // Fixed-point format of the CORDIC result (unsigned, no sign bit)
   localparam int FRACS      = 21;
   localparam int INTS       = 1;

   // IEEE-754 single-precision layout
   localparam int FLOAT_BIAS = 127;
   localparam int FLOAT_W    = 32;
   localparam int MANT_W     = 23;
   localparam int EXP_W      = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NORM = 2'd1,
      DONE = 2'd2
   } f2f_state_t;

   // Packs a positive float. The CORDIC cosine output is never negative, so
   // the sign bit is always 0.
   function automatic logic [FLOAT_W-1:0] pack_float(
      input logic [EXP_W-1:0]  exp_field,
      input logic [MANT_W-1:0] mant_field
   );
      return {1'b0, exp_field, mant_field};
   endfunction

endpackage

// File: rtl/cordic_fix2float.sv
// ----------------------------------------------------------------------------
// cordic_fix2float
//   Converts the unsigned fixed-point CORDIC result to an IEEE-754 single.
//   An iterative normaliser shifts the value left one bit per cycle until the
//   MSB is set. Each shift lowers the exponent by one. Then the sign,
//   exponent and mantissa are packed into the result. The input has fewer
//   bits than the 24-bit significand, so the conversion is always exact.
//
// Ports
//   clk       in   1     clock
//   reset     in   1     synchronous active-high reset (wins over everything)
//   clk_en    in   1     clock enable; low freezes all state and outputs
//   start     in   1     accepted only in IDLE; captures fixed_in
//   fixed_in  in   IN_W  unsigned value = fixed_in / 2^FRACS
//   done      out  1     registered one-cycle pulse; result valid with it
//   result    out  32    {sign, exp[7:0], mant[22:0]}, held until rewritten
// ----------------------------------------------------------------------------
module cordic_fix2float
   import cordic_pkg::*;
#(
   parameter int FRACS_P = cordic_pkg::FRACS,
   parameter int INTS_P  = cordic_pkg::INTS
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clk_en,
   input  logic                       start,
   input  logic [INTS_P+FRACS_P-1:0]  fixed_in,
   output logic                       done,
   output logic [FLOAT_W-1:0]         result
);

   localparam int IN_W  = INTS_P + FRACS_P;
   // Zero bits that left-align the fraction inside the 23-bit mantissa
   localparam int PAD_W = MANT_W + 1 - IN_W;
   // Exponent of the input MSB position, before any normalising shift
   localparam logic [EXP_W-1:0] EXP_INIT = EXP_W'(FLOAT_BIAS + INTS_P - 1);

   f2f_state_t            state_r;
   f2f_state_t            state_next_s;
   logic [IN_W-1:0]       sreg_r;
   logic [EXP_W-1:0]      exp_cnt_r;
   logic [FLOAT_W-1:0]    result_r;
   logic                  done_r;
   logic [MANT_W-1:0]     mant_s;

   // The hidden bit (MSB of sreg) is dropped and the fraction is left-aligned
   assign mant_s = {sreg_r[IN_W-2:0], {PAD_W{1'b0}}};

   // Next-state decode of the normaliser FSM
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               if (fixed_in == {IN_W{1'b0}}) begin
                  state_next_s = DONE;
               end else begin
                  state_next_s = NORM;
               end
            end else begin
               state_next_s = IDLE;
            end
         end
         NORM: begin
            if (sreg_r[IN_W-1]) begin
               state_next_s = DONE;
            end else begin
               state_next_s = NORM;
            end
         end
         DONE:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // State, shift register, exponent counter, result and done registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         sreg_r    <= {IN_W{1'b0}};
         exp_cnt_r <= {EXP_W{1'b0}};
         result_r  <= {FLOAT_W{1'b0}};
         done_r    <= 1'b0;
      end else if (clk_en) begin
         state_r <= state_next_s;
         // done is high for exactly the cycles spent in DONE
         done_r  <= (state_next_s == DONE);
         case (state_r)
            IDLE: begin
               if (start) begin
                  sreg_r    <= fixed_in;
                  exp_cnt_r <= EXP_INIT;
                  // Zero has no leading one, so it bypasses the normaliser
                  if (fixed_in == {IN_W{1'b0}}) begin
                     result_r <= {FLOAT_W{1'b0}};
                  end
               end
            end
            NORM: begin
               if (sreg_r[IN_W-1]) begin
                  result_r <= pack_float(exp_cnt_r, mant_s);
               end else begin
                  sreg_r    <= sreg_r << 1;
                  exp_cnt_r <= exp_cnt_r - 8'd1;
               end
            end
            DONE: begin
               sreg_r <= sreg_r;
            end
            default: begin
               sreg_r <= sreg_r;
            end
         endcase
      end
   end

   assign done   = done_r;
   assign result = result_r;

endmodule
